ex_stage_mdu: RTL and testbench
===============================

Name: ex_stage_mdu

Overview:
- Parametrised next-generation execute stage for the 5-stage RISC-V pipeline.
- Keeps ALU, ALU control, forwarding muxes and the EX/MEM pipeline register.
- Adds an iterative multiply/divide unit (RV32M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Adds a stall handshake to the hazard unit, plus a flush input from branch resolution.

Parameters:
XLEN, 32, datapath width (operands, immediate, results).
REG_W, 5, register-index width.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
valid_in  in  1  ID/EX holds a real instruction (0 = bubble)
flush_in  in  1  kill the instruction in EX; abort any M operation
reg_a_in  in  XLEN  rs1 value from ID/EX
reg_b_in  in  XLEN  rs2 value from ID/EX
mem_to_reg_in, reg_write_in  in  1 each  WB controls
mem_read_in, mem_write_in, beq_instruction_in  in  1 each  MEM controls
aluSrc_in  in  1  0 = forwarded rs2, 1 = immediate
aluOp_in  in  2  ALU operation class (2'b10 = R-type)
funct7_in  in  7  instruction funct7
funct3_in  in  3  instruction funct3
reg_rs1_in, reg_rs2_in, reg_rd_in  in  REG_W each  register indices
immediate_in  in  XLEN  sign-extended immediate
ex_mem_reg_rd  in  REG_W  forwarding source: EX/MEM destination register
ex_mem_reg_write  in  1  forwarding source: EX/MEM write enable
mem_wb_reg_rd  in  REG_W  forwarding source: MEM/WB destination register
mem_wb_reg_write  in  1  forwarding source: MEM/WB write enable
alu_ex_mem  in  XLEN  EX/MEM forward data
alu_data_mem_wb  in  XLEN  MEM/WB forward data
stall_out  out  1  combinational; freeze PC, IF/ID and ID/EX
rd_ex  out  REG_W  reg_rd_in, passed to ID
mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out  out  1 each  registered controls
alu_result_out  out  XLEN  registered ALU or MDU result
mux2_result_out  out  XLEN  registered forwarded rs2 (store data)
reg_rd_out  out  REG_W  registered rd
flag_beq_out  out  1  registered ALU zero flag

Behaviour:
- Reset (reset=0, async): all registered outputs 0; FSM in IDLE; stall_out 0.
- Forwarding priority per operand:
  - EX/MEM match (write=1, rd!=0, rd==rs) wins over MEM/WB match.
  - Otherwise the ID/EX value is used.
- M-op decode: valid_in & aluOp_in==2'b10 & funct7_in==7'b0000001. All other valid instructions are 1-cycle ALU ops with latency 1 into EX/MEM.
- FSM states:
  - IDLE:
    - M-op present and no flush: latch forwarded operands, funct3 and rd/controls into internal regs.
    - Assert stall_out in that same cycle; EX/MEM loads a bubble (all controls 0, data 0); go to BUSY with count = XLEN-1.
  - BUSY:
    - One radix-2 step per cycle: shift-add multiply or restoring divide on magnitudes.
    - stall_out=1; EX/MEM loads a bubble.
    - Operands come only from the latched regs; forwarding sources are ignored.
    - At count==0 go to DONE.
  - DONE:
    - stall_out=0.
    - Apply sign correction and select the result: low/high half, quotient or remainder.
    - EX/MEM captures the result with the latched controls; return to IDLE.
  - Stall totals: stall_out is high for XLEN+1 cycles; the M-op occupies EX for XLEN+2 cycles.
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - The product is 2*XLEN bits internally.
- Special cases (override after iteration, same latency):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1); remainder = 0.
- Flush:
  - flush_in=1 forces EX/MEM to a bubble and the FSM to IDLE next edge.
  - stall_out drops combinationally in the flush cycle.
  - flush has priority over accept and DONE.
- Reset mid-operation: FSM returns to IDLE immediately; no result is written.
- rd_ex always equals reg_rd_in (combinational).

Optional Feature:
- Macro: FAST_MUL_EN
- Defined:
  - MUL/MULH/MULHSU/MULHU complete in 1 cycle via a combinational XLEN x XLEN multiplier; no stall.
  - Division still iterates as above.
- Undefined: all M-ops use the iterative FSM; no hardware multiplier is inferred.

Test Plan:
- ADD x3=x1+x2 with x1 forwarded from EX/MEM (alu_ex_mem=5) and x2=7 -> next cycle alu_result_out=12, reg_rd_out=3, stall_out never high.
- MUL 7 * -3 (0xFFFFFFFD), XLEN=32, FAST_MUL_EN undefined:
  - stall_out high exactly 33 cycles; bubbles in EX/MEM during the stall.
  - Then alu_result_out=0xFFFFFFEB.
- DIVU 100/0 -> alu_result_out=0xFFFFFFFF; REMU 100/0 -> 100.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- DIV 20/3 with flush_in pulsed in BUSY cycle 10 -> stall_out low that cycle, EX/MEM bubble, no result ever written; the next ADD executes normally.
- reset pulsed low mid-division -> all outputs 0 asynchronously and FSM IDLE; after release an ADD produces a correct result in 1 cycle.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding, ALU, EX/MEM register and an iterative RV32M multiply/divide unit.
// Optional `FAST_MUL_EN: multiplies complete in one cycle on a combinational multiplier.
module ex_stage_mdu #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             flush_in,
  input  logic [XLEN-1:0]  reg_a_in,
  input  logic [XLEN-1:0]  reg_b_in,
  input  logic             mem_to_reg_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             beq_instruction_in,
  input  logic             aluSrc_in,
  input  logic [1:0]       aluOp_in,
  input  logic [6:0]       funct7_in,
  input  logic [2:0]       funct3_in,
  input  logic [REG_W-1:0] reg_rs1_in,
  input  logic [REG_W-1:0] reg_rs2_in,
  input  logic [REG_W-1:0] reg_rd_in,
  input  logic [XLEN-1:0]  immediate_in,
  input  logic [REG_W-1:0] ex_mem_reg_rd,
  input  logic             ex_mem_reg_write,
  input  logic [REG_W-1:0] mem_wb_reg_rd,
  input  logic             mem_wb_reg_write,
  input  logic [XLEN-1:0]  alu_ex_mem,
  input  logic [XLEN-1:0]  alu_data_mem_wb,
  output logic             stall_out,
  output logic [REG_W-1:0] rd_ex,
  output logic             mem_to_reg_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic             beq_instruction_out,
  output logic [XLEN-1:0]  alu_result_out,
  output logic [XLEN-1:0]  mux2_result_out,
  output logic [REG_W-1:0] reg_rd_out,
  output logic             flag_beq_out
);

  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg;
  logic [SH_W-1:0]  count_reg;
  logic [XLEN-1:0]  hi_reg, lo_reg, opb_reg, dividend_reg, rs2_reg;
  logic [2:0]       funct3_reg;
  logic             neg_a_reg, neg_b_reg, div_zero_reg, ovf_reg;
  logic [REG_W-1:0] rd_reg;
  logic [4:0]       ctl_reg;

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res, ex_res;
  logic [SH_W-1:0] shamt;
  logic            alt;

  always_comb begin
    fwd_a = reg_a_in;
    if (ex_mem_reg_write && ex_mem_reg_rd != '0 && ex_mem_reg_rd == reg_rs1_in)
      fwd_a = alu_ex_mem;
    else if (mem_wb_reg_write && mem_wb_reg_rd != '0 && mem_wb_reg_rd == reg_rs1_in)
      fwd_a = alu_data_mem_wb;
    fwd_b = reg_b_in;
    if (ex_mem_reg_write && ex_mem_reg_rd != '0 && ex_mem_reg_rd == reg_rs2_in)
      fwd_b = alu_ex_mem;
    else if (mem_wb_reg_write && mem_wb_reg_rd != '0 && mem_wb_reg_rd == reg_rs2_in)
      fwd_b = alu_data_mem_wb;
  end

  assign alu_b = aluSrc_in ? immediate_in : fwd_b;
  assign shamt = alu_b[SH_W-1:0];
  // funct7[5] selects SUB only for R-type, but selects SRA for both R-type and SRAI
  assign alt   = funct7_in[5] & ((aluOp_in == 2'b10) | (funct3_in == 3'b101));

  always_comb begin
    alu_res = fwd_a + alu_b;
    case (aluOp_in)
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      default: begin
        case (funct3_in)
          3'b000:  alu_res = alt ? fwd_a - alu_b : fwd_a + alu_b;
          3'b001:  alu_res = fwd_a << shamt;
          3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
          3'b011:  alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
          3'b100:  alu_res = fwd_a ^ alu_b;
          3'b101:  alu_res = alt ? $unsigned($signed(fwd_a) >>> shamt) : fwd_a >> shamt;
          3'b110:  alu_res = fwd_a | alu_b;
          default: alu_res = fwd_a & alu_b;
        endcase
      end
    endcase
  end

  logic is_mop, iter_mop, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_mop   = valid_in & (aluOp_in == 2'b10) & (funct7_in == 7'b0000001);
  assign a_signed = (funct3_in != 3'b011) & (funct3_in != 3'b101) & (funct3_in != 3'b111);
  assign b_signed = a_signed & (funct3_in != 3'b010);
  assign neg_a    = a_signed & fwd_a[XLEN-1];
  assign neg_b    = b_signed & fwd_b[XLEN-1];
  assign mag_a    = neg_a ? -fwd_a : fwd_a;
  assign mag_b    = neg_b ? -fwd_b : fwd_b;

`ifdef FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic                     fast_mop;
  assign iter_mop  = is_mop & funct3_in[2];
  assign fast_mop  = is_mop & ~funct3_in[2];
  assign fast_prod = $signed({a_signed & fwd_a[XLEN-1], fwd_a}) *
                     $signed({b_signed & fwd_b[XLEN-1], fwd_b});
  assign ex_res    = !fast_mop ? alu_res :
                     (funct3_in[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign iter_mop = is_mop;
  assign ex_res   = alu_res;
`endif

  // One radix-2 step: shift-add multiply, or restoring divide with the dividend shifting out of lo
  logic [XLEN:0] mul_sum, div_shift, div_trial;
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opb_reg};

  logic [2*XLEN-1:0] prod_mag, prod_signed;
  logic [XLEN-1:0]   quot, rem, mdu_res;
  always_comb begin
    prod_mag    = {hi_reg, lo_reg};
    prod_signed = (neg_a_reg ^ neg_b_reg) ? -prod_mag : prod_mag;
    quot        = (neg_a_reg ^ neg_b_reg) ? -lo_reg : lo_reg;
    rem         = neg_a_reg ? -hi_reg : hi_reg;
    case (funct3_reg)
      3'b000:         mdu_res = prod_signed[XLEN-1:0];
      3'b100, 3'b101: mdu_res = div_zero_reg ? '1 : ovf_reg ? {1'b1, {(XLEN-1){1'b0}}} : quot;
      3'b110, 3'b111: mdu_res = div_zero_reg ? dividend_reg : ovf_reg ? '0 : rem;
      default:        mdu_res = prod_signed[2*XLEN-1:XLEN];
    endcase
  end

  assign stall_out = reset & ~flush_in & (((state_reg == IDLE) & iter_mop) | (state_reg == BUSY));
  assign rd_ex     = reg_rd_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      hi_reg <= '0; lo_reg <= '0; opb_reg <= '0; dividend_reg <= '0; rs2_reg <= '0;
      funct3_reg <= '0; rd_reg <= '0; ctl_reg <= '0;
      neg_a_reg <= 1'b0; neg_b_reg <= 1'b0; div_zero_reg <= 1'b0; ovf_reg <= 1'b0;
      {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out} <= '0;
      alu_result_out <= '0; mux2_result_out <= '0; reg_rd_out <= '0; flag_beq_out <= 1'b0;
    end else begin
      // Bubble unless a result is committed below
      {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out} <= '0;
      alu_result_out <= '0; mux2_result_out <= '0; reg_rd_out <= '0; flag_beq_out <= 1'b0;
      if (flush_in) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (iter_mop) begin
              hi_reg       <= '0;
              lo_reg       <= mag_a;
              opb_reg      <= mag_b;
              dividend_reg <= fwd_a;
              rs2_reg      <= fwd_b;
              neg_a_reg    <= neg_a;
              neg_b_reg    <= neg_b;
              div_zero_reg <= (fwd_b == '0);
              ovf_reg      <= b_signed & (fwd_a == {1'b1, {(XLEN-1){1'b0}}}) & (fwd_b == '1);
              funct3_reg   <= funct3_in;
              rd_reg       <= reg_rd_in;
              ctl_reg      <= {mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in};
              count_reg    <= SH_W'(XLEN-1);
              state_reg    <= BUSY;
            end else if (valid_in) begin
              {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out} <=
                {mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in};
              alu_result_out  <= ex_res;
              mux2_result_out <= fwd_b;
              reg_rd_out      <= reg_rd_in;
              flag_beq_out    <= (ex_res == '0);
            end
          end
          BUSY: begin
            if (funct3_reg[2]) begin
              hi_reg <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
              lo_reg <= {lo_reg[XLEN-2:0], ~div_trial[XLEN]};
            end else begin
              hi_reg <= mul_sum[XLEN:1];
              lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
            end
            if (count_reg == '0) state_reg <= DONE;
            else                 count_reg <= count_reg - 1'b1;
          end
          DONE: begin
            {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out} <= ctl_reg;
            alu_result_out  <= mdu_res;
            mux2_result_out <= rs2_reg;
            reg_rd_out      <= rd_reg;
            flag_beq_out    <= (mdu_res == '0);
            state_reg       <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: expected write-backs queued at issue, compared on EX/MEM output.
module tb_ex_stage_mdu;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic clock, reset, valid_in, flush_in;
  logic [XLEN-1:0] reg_a_in, reg_b_in, immediate_in, alu_ex_mem, alu_data_mem_wb;
  logic mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in, aluSrc_in;
  logic [1:0] aluOp_in;
  logic [6:0] funct7_in;
  logic [2:0] funct3_in;
  logic [REG_W-1:0] reg_rs1_in, reg_rs2_in, reg_rd_in, ex_mem_reg_rd, mem_wb_reg_rd;
  logic ex_mem_reg_write, mem_wb_reg_write;
  logic stall_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out;
  logic beq_instruction_out, flag_beq_out;
  logic [REG_W-1:0] rd_ex, reg_rd_out;
  logic [XLEN-1:0] alu_result_out, mux2_result_out;

  ex_stage_mdu #(.XLEN(XLEN), .REG_W(REG_W)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .flush_in(flush_in),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .beq_instruction_in(beq_instruction_in), .aluSrc_in(aluSrc_in),
    .aluOp_in(aluOp_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
    .reg_rs1_in(reg_rs1_in), .reg_rs2_in(reg_rs2_in), .reg_rd_in(reg_rd_in),
    .immediate_in(immediate_in), .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_reg_rd(mem_wb_reg_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .alu_ex_mem(alu_ex_mem), .alu_data_mem_wb(alu_data_mem_wb),
    .stall_out(stall_out), .rd_ex(rd_ex), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .beq_instruction_out(beq_instruction_out), .alu_result_out(alu_result_out),
    .mux2_result_out(mux2_result_out), .reg_rd_out(reg_rd_out), .flag_beq_out(flag_beq_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  res;
    logic [4:0]       ctl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt;
  logic last_stall;
  int   st;

  // Directed corner cases with hand-derived results
  logic [2:0]      cf3 [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
  logic [XLEN-1:0] ca  [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
  logic [XLEN-1:0] cb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [XLEN-1:0] cex [4] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0};
  // Further M-ops whose results come from the reference model
  logic [2:0]      tf3 [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [XLEN-1:0] ta  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
  logic [XLEN-1:0] tb  [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'hFFFF_FFFF, 32'd5};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] mdu_ref(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb);              return p[31:0];  end
      3'd1: begin p = 64'(sa * sb);              return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub));    return p[63:32]; end
      3'd3: begin p = ua * ub;                   return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic [REG_W-1:0] rd, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                       input logic src, input logic [4:0] ctl);
    valid_in = 1'b1; aluOp_in = op; funct7_in = f7; funct3_in = f3;
    reg_rs1_in = rs1; reg_rs2_in = rs2; reg_rd_in = rd;
    reg_a_in = a; reg_b_in = b; immediate_in = imm; aluSrc_in = src;
    {mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in} = ctl;
  endtask

  task automatic bubble_in();
    valid_in = 1'b0; aluOp_in = 2'b00; funct7_in = '0; funct3_in = '0;
    {mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in} = '0;
  endtask

  task automatic fwd_clear();
    ex_mem_reg_write = 1'b0; ex_mem_reg_rd = '0; alu_ex_mem = '0;
    mem_wb_reg_write = 1'b0; mem_wb_reg_rd = '0; alu_data_mem_wb = '0;
  endtask

  // One clock: sample stall mid-cycle, then inspect what EX/MEM captured at the edge
  task automatic tick();
    exp_t e;
    #2;
    last_stall = stall_out;
    if (last_stall) stall_cnt++;
    @(posedge clock);
    #1;
    if (last_stall) begin
      check_eq("bubble_ctl", {reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out,
                              beq_instruction_out, flag_beq_out, reg_rd_out}, '0);
      check_eq("bubble_data", {alu_result_out, mux2_result_out}, '0);
    end else if (reg_write_out) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_wb", 64'(reg_write_out), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", alu_result_out, e.res);
        check_eq("rd", reg_rd_out, e.rd);
        check_eq("ctl", {mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
                         beq_instruction_out}, e.ctl);
        check_eq("zero_flag", flag_beq_out, e.res == '0);
      end
    end
  endtask

  // Hold the driven instruction while the stage stalls; scramble forwarding inputs meanwhile
  task automatic issue(input logic [XLEN-1:0] res, output int stalls);
    exp_t e;
    e.rd = reg_rd_in; e.res = res;
    e.ctl = {mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in};
    sb_q.push_back(e);
    stall_cnt = 0;
    tick();
    for (int n = 0; last_stall && n < 100; n++) begin
      if (n == 0) begin
        ex_mem_reg_write = 1'b1; ex_mem_reg_rd = reg_rs1_in; alu_ex_mem = 32'hDEAD_BEEF;
        mem_wb_reg_write = 1'b1; mem_wb_reg_rd = reg_rs2_in; alu_data_mem_wb = 32'h0BAD_F00D;
      end
      tick();
    end
    check_eq("stall_released", last_stall, 1'b0);
    fwd_clear();
    stalls = stall_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush_in = 1'b0;
    reg_a_in = '0; reg_b_in = '0; immediate_in = '0; aluSrc_in = 1'b0;
    reg_rs1_in = '0; reg_rs2_in = '0; reg_rd_in = '0;
    bubble_in();
    fwd_clear();
    #12;
    check_eq("rst_ctl", {reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out,
                         beq_instruction_out, flag_beq_out, reg_rd_out}, '0);
    check_eq("rst_data", {alu_result_out, mux2_result_out}, '0);
    check_eq("rst_stall", stall_out, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;

    // ADD x3 = x1 + x2, x1 forwarded from EX/MEM
    ex_mem_reg_write = 1'b1; ex_mem_reg_rd = 5'd1; alu_ex_mem = 32'd5;
    drive(2'b10, 7'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd99, 32'd7, 32'd0, 1'b0, 5'b01000);
    #1 check_eq("rd_ex", rd_ex, 5'd3);
    issue(32'd12, st);
    check_eq("add_stalls", st, 0);

    // SUB with both forwarding sources matching rs1: EX/MEM wins (5 - 7)
    ex_mem_reg_write = 1'b1; ex_mem_reg_rd = 5'd1; alu_ex_mem = 32'd5;
    mem_wb_reg_write = 1'b1; mem_wb_reg_rd = 5'd1; alu_data_mem_wb = 32'd50;
    drive(2'b10, 7'h20, 3'd0, 5'd1, 5'd2, 5'd4, 32'd99, 32'd7, 32'd0, 1'b0, 5'b01000);
    issue(32'hFFFF_FFFE, st);

    // x0 is never forwarded; rs2 comes from MEM/WB and doubles as store data
    ex_mem_reg_write = 1'b1; ex_mem_reg_rd = 5'd0; alu_ex_mem = 32'd1000;
    mem_wb_reg_write = 1'b1; mem_wb_reg_rd = 5'd2; alu_data_mem_wb = 32'd40;
    drive(2'b10, 7'd0, 3'd0, 5'd0, 5'd2, 5'd5, 32'd0, 32'd3, 32'd0, 1'b0, 5'b01000);
    issue(32'd40, st);
    check_eq("store_data", mux2_result_out, 32'd40);

    // Load-style address add with immediate, and a zero result through the subtract class
    drive(2'b00, 7'd0, 3'd2, 5'd1, 5'd9, 5'd6, 32'd10, 32'd77, 32'hFFFF_FFFC, 1'b1, 5'b11100);
    issue(32'd6, st);
    drive(2'b01, 7'd0, 3'd0, 5'd1, 5'd2, 5'd14, 32'd5, 32'd5, 32'd0, 1'b0, 5'b01001);
    issue(32'd0, st);

    // MUL 7 * -3
    drive(2'b10, 7'd1, 3'd0, 5'd6, 5'd7, 5'd8, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 5'b01000);
    issue(32'hFFFF_FFEB, st);
    check_eq("mul_stalls", st, 33);

    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 7'd1, cf3[i], 5'd6, 5'd7, 5'd9, ca[i], cb[i], 32'd0, 1'b0, 5'b01000);
      issue(cex[i], st);
      check_eq("corner_stalls", st, 33);
    end

    for (int i = 0; i < 11; i++) begin
      logic [2:0] f3;
      logic [XLEN-1:0] a, b;
      if (i < 7) begin f3 = tf3[i]; a = ta[i]; b = tb[i]; end
      else begin f3 = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; end
      drive(2'b10, 7'd1, f3, 5'd6, 5'd7, 5'(10 + i), a, b, 32'd0, 1'b0, 5'b01000);
      issue(mdu_ref(f3, a, b), st);
      check_eq("mdu_stalls", st, 33);
    end

    // DIV 20/3 flushed in BUSY cycle 10: nothing may ever be written for it
    drive(2'b10, 7'd1, 3'd4, 5'd6, 5'd7, 5'd9, 32'd20, 32'd3, 32'd0, 1'b0, 5'b01000);
    for (int i = 0; i < 10; i++) tick();
    flush_in = 1'b1;
    #1 check_eq("flush_stall", stall_out, 1'b0);
    tick();
    check_eq("flush_bubble", {reg_write_out, alu_result_out}, '0);
    flush_in = 1'b0;
    drive(2'b10, 7'd0, 3'd0, 5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0, 1'b0, 5'b01000);
    issue(32'd3, st);
    check_eq("post_flush_stalls", st, 0);
    bubble_in();
    for (int i = 0; i < 40; i++) tick();

    // Reset must clear EX/MEM without waiting for a clock edge
    drive(2'b10, 7'd0, 3'd0, 5'd1, 5'd2, 5'd11, 32'd4, 32'd5, 32'd0, 1'b0, 5'b01000);
    issue(32'd9, st);
    drive(2'b10, 7'd1, 3'd4, 5'd6, 5'd7, 5'd12, 32'd20, 32'd3, 32'd0, 1'b0, 5'b01000);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_data", alu_result_out, 32'd0);
    check_eq("async_rst_ctl", {reg_write_out, reg_rd_out}, '0);
    check_eq("async_rst_stall", stall_out, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #2 reset = 1'b0;
    #1 check_eq("mid_div_rst_stall", stall_out, 1'b0);
    check_eq("mid_div_rst_out", {reg_write_out, alu_result_out}, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    drive(2'b10, 7'd0, 3'd0, 5'd1, 5'd2, 5'd13, 32'd8, 32'd9, 32'd0, 1'b0, 5'b01000);
    issue(32'd17, st);
    check_eq("post_rst_stalls", st, 0);
    bubble_in();
    for (int i = 0; i < 40; i++) tick();
    check_eq("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
